sram_req_arbiter: RTL

//  Shares one SRAM-like bus between the IF-stage instruction port and the EX/MEM data port.

---
 rtl/sram_req_arbiter_pkg.sv | 32 +++
 rtl/sram_req_arbiter_if.sv | 27 ++
 rtl/sram_req_arbiter_tag_fifo.sv | 54 +++++
 rtl/sram_req_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and constants for the SRAM-like request arbiter.
// Holds the size-field width, the source tags stored in the tag FIFO,
// the arbiter FSM state encodings and the packed request payload.
package sram_req_arbiter_pkg;

  localparam int unsigned ARB_MAX_OUTSTANDING = 4;
  localparam int unsigned ARB_PTR_W           = 2;
  localparam int unsigned SRAM_SIZE_W         = 2;
  localparam int unsigned SRAM_ADDR_W         = 32;
  localparam int unsigned SRAM_DATA_W         = 32;
  localparam int unsigned SRAM_STRB_W         = 4;

  // Source tag recorded per accepted request
  localparam logic TAG_DATA = 1'b1;
  localparam logic TAG_INST = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_D = 2'd1,
    ARB_HOLD_I = 2'd2
  } arb_state_e;

  // Request payload carried alongside req
  typedef struct packed {
    logic                   wr;
    logic [SRAM_SIZE_W-1:0] size;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_STRB_W-1:0] wstrb;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_if.sv
// SRAM-like handshake bundle.
// master: drives req + payload, receives addr_ok/data_ok/rdata.
// slave : receives req + payload, drives addr_ok/data_ok/rdata.
interface sram_req_arbiter_if;
  import sram_req_arbiter_pkg::*;

  logic                   req;
  logic                   wr;
  logic [SRAM_SIZE_W-1:0] size;
  logic [SRAM_ADDR_W-1:0] addr;
  logic [SRAM_STRB_W-1:0] wstrb;
  logic [SRAM_DATA_W-1:0] wdata;
  logic                   addr_ok;
  logic                   data_ok;
  logic [SRAM_DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order FIFO of source tags for accepted-but-unanswered requests.
// Ports: clk, reset (sync, active-high), push/push_tag, pop,
//        full, empty, head (combinational view of the oldest entry).
// Push while full is only honoured when a pop frees the slot the same cycle;
// pop while empty is ignored.
module arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_tag,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like bus between the instruction and data ports.
// Ports: clk, reset (sync, active-high);
//        inst_if/data_if (slave)  - pipeline-side request ports;
//        bus_if (master)          - merged request towards the AXI bridge.
// One address handshake per cycle, data before instruction; a stalled
// request is locked until accepted. Responses are steered back using an
// in-order tag FIFO, with zero-cycle latency.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
  parameter int unsigned PTR_W           = ARB_PTR_W
) (
  input  logic                clk,
  input  logic                reset,
  sram_req_arbiter_if.slave   inst_if,
  sram_req_arbiter_if.slave   data_if,
  sram_req_arbiter_if.master  bus_if
);

  arb_state_e state;
  arb_state_e state_nxt;

  logic      reset_q;
  logic      active;
  logic      src_data;
  logic      bus_req_c;
  logic      grant;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      full_eff;
  logic      head_tag;
  logic      push_tag;
  sram_req_t inst_pay;
  sram_req_t data_pay;
  sram_req_t bus_pay;

  // Outputs stay quiet in the reset cycle and the one after it
  always_ff @(posedge clk) reset_q <= reset;
  assign active = ~reset & ~reset_q;

  assign inst_pay = {inst_if.wr, inst_if.size, inst_if.addr, inst_if.wstrb, inst_if.wdata};
  assign data_pay = {data_if.wr, data_if.size, data_if.addr, data_if.wstrb, data_if.wdata};

  // A response in the same cycle frees a slot for a new request
  assign pop      = active & bus_if.data_ok & ~fifo_empty;
  assign full_eff = fifo_full & ~pop;
  assign grant    = bus_req_c & bus_if.addr_ok;
  assign push_tag = src_data ? TAG_DATA : TAG_INST;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1),
    .AW    (PTR_W)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (grant),
    .push_tag (push_tag),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_tag)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Next state: lock the source while the bridge stalls
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (bus_req_c & ~bus_if.addr_ok)
          state_nxt = src_data ? ARB_HOLD_D : ARB_HOLD_I;
      end
      ARB_HOLD_D,
      ARB_HOLD_I: begin
        if (bus_if.addr_ok) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs: source select, request mux, grants and response demux
  always_comb begin
    src_data        = 1'b0;
    bus_req_c       = 1'b0;
    bus_pay         = '0;
    inst_if.addr_ok = 1'b0;
    data_if.addr_ok = 1'b0;
    inst_if.data_ok = 1'b0;
    data_if.data_ok = 1'b0;
    inst_if.rdata   = '0;
    data_if.rdata   = '0;

    case (state)
      ARB_IDLE: begin
        src_data  = data_if.req;
        bus_req_c = active & (inst_if.req | data_if.req) & ~full_eff;
      end
      ARB_HOLD_D: begin
        src_data  = 1'b1;
        bus_req_c = active;
      end
      ARB_HOLD_I: begin
        src_data  = 1'b0;
        bus_req_c = active;
      end
      default: begin
        src_data  = 1'b0;
        bus_req_c = 1'b0;
      end
    endcase

    if (bus_req_c) bus_pay = src_data ? data_pay : inst_pay;

    data_if.addr_ok = bus_req_c & bus_if.addr_ok & src_data;
    inst_if.addr_ok = bus_req_c & bus_if.addr_ok & ~src_data;

    if (pop) begin
      if (head_tag == TAG_DATA) begin
        data_if.data_ok = 1'b1;
        data_if.rdata   = bus_if.rdata;
      end else begin
        inst_if.data_ok = 1'b1;
        inst_if.rdata   = bus_if.rdata;
      end
    end
  end

  assign bus_if.req   = bus_req_c;
  assign bus_if.wr    = bus_pay.wr;
  assign bus_if.size  = bus_pay.size;
  assign bus_if.addr  = bus_pay.addr;
  assign bus_if.wstrb = bus_pay.wstrb;
  assign bus_if.wdata = bus_pay.wdata;

  // A response with nothing outstanding is a bridge protocol error
  always_ff @(posedge clk) begin
    if (active && bus_if.data_ok)
      assert (!fifo_empty)
      else $warning("sram_req_arbiter: bus data_ok with no outstanding request ignored");
  end

endmodule
